// File: rtl/vga_frame_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_fetch_ctrl_if
// Description : Memory read port and AXI4-Stream pixel port of the frame fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tuser;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rdata, mem_rvalid,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rdata, mem_rvalid,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/vga_frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_fetch_ctrl
// Description : Credit-limited framebuffer reader feeding an AXI4-Stream pixel
//               output through a first-word-fall-through FIFO.
//               Optional starvation counter: define VGA_FETCH_STARV_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_fetch_ctrl #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  enable,
  input  wire logic                  frame_start,
  input  wire logic [ADDR_WIDTH-1:0] fb_base,
  vga_frame_fetch_ctrl_if.master     bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun_sticky
`ifdef VGA_FETCH_STARV_CNT_EN
  ,
  output logic [15:0]                starve_count
`endif
);

  localparam int c_total = H_ACTIVE * V_ACTIVE;
  localparam int c_pix_w = (c_total > 1) ? $clog2(c_total) : 1;
  localparam int c_x_w   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int c_y_w   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);

  localparam logic [c_pix_w-1:0] c_last_idx = c_pix_w'(c_total - 1);
  localparam logic [c_x_w-1:0]   c_x_last   = c_x_w'(H_ACTIVE - 1);
  localparam logic [c_y_w-1:0]   c_y_last   = c_y_w'(V_ACTIVE - 1);
  localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FETCH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_done_nxt, w_busy;
  logic   r_frame_done, r_overrun;

  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [c_pix_w-1:0]    r_req_idx, w_idx_nxt;
  logic [c_cnt_w-1:0]    r_outstanding, w_out_nxt;
  logic [c_cnt_w-1:0]    r_count, w_cnt_nxt;
  logic [c_cnt_w:0]      w_credit_sum;
  logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [c_x_w-1:0]      r_x;
  logic [c_y_w-1:0]      r_y;

  logic w_start, w_grant, w_push, w_pop, w_tvalid;
  logic w_last_grant, w_last_beat, w_credit_ok;

  assign w_start      = (r_state == S_ARMED) && enable && frame_start;
  assign w_grant      = r_mem_req && bus.mem_gnt;
  // Returns with nothing outstanding are leftovers from an aborted frame.
  assign w_push       = bus.mem_rvalid && (r_outstanding != '0);
  assign w_tvalid     = (r_count != '0);
  assign w_pop        = w_tvalid && bus.m_axis_tready;
  assign w_last_grant = w_grant && (r_req_idx == c_last_idx);
  assign w_last_beat  = w_pop && (r_x == c_x_last) && (r_y == c_y_last);

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_grant, w_push})
      2'b10:   w_out_nxt = r_outstanding + c_cnt_w'(1);
      2'b01:   w_out_nxt = r_outstanding - c_cnt_w'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_cnt_nxt = r_count - c_cnt_w'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Credit is judged on next-cycle occupancy because mem_req is registered.
  assign w_credit_sum = {1'b0, w_out_nxt} + {1'b0, w_cnt_nxt};
  assign w_credit_ok  = (w_credit_sum < c_depth);
  assign w_idx_nxt    = w_grant ? (r_req_idx + c_pix_w'(1)) : r_req_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done_nxt;
      if (frame_start && ((r_state == S_FETCH) || (r_state == S_DRAIN))) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!enable)          w_state_nxt = S_IDLE;
        else if (frame_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_busy = 1'b1;
        if (w_last_grant) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_last_beat) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = enable ? S_ARMED : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_base        <= '0;
      r_req_idx     <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_start) begin
        r_base     <= fb_base;
        r_req_idx  <= '0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= fb_base;
      end else if (r_state == S_FETCH) begin
        r_req_idx <= w_idx_nxt;
        if (w_last_grant) begin
          r_mem_req <= 1'b0;
        end else if (!r_mem_req || bus.mem_gnt) begin
          r_mem_req  <= w_credit_ok;
          r_mem_addr <= r_base + ADDR_WIDTH'(w_idx_nxt);
        end
      end else begin
        r_mem_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= (r_y == c_y_last) ? '0 : (r_y + c_y_w'(1));
      end else begin
        r_x <= r_x + c_x_w'(1);
      end
    end
  end

`ifdef VGA_FETCH_STARV_CNT_EN
  logic [15:0] r_starve;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_start) begin
      r_starve <= '0;
    end else if (w_busy && bus.m_axis_tready && !w_tvalid && (r_starve != 16'hFFFF)) begin
      r_starve <= r_starve + 16'd1;
    end
  end

  assign starve_count = r_starve;
`else
`endif

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tdata  = w_tvalid ? r_fifo[r_rd_ptr] : '0;
  assign bus.m_axis_tuser  = w_tvalid && (r_x == '0) && (r_y == '0);
  assign bus.m_axis_tlast  = w_tvalid && (r_x == c_x_last);
  assign busy              = w_busy;
  assign frame_done        = r_frame_done;
  assign overrun_sticky    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_fetch_ctrl
// Description : Directed scoreboard bench for vga_frame_fetch_ctrl (4x2 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_fetch_ctrl;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int FD = 4;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          frame_start;
  logic [AW-1:0] fb_base;
  logic          busy;
  logic          frame_done;
  logic          overrun_sticky;
`ifdef VGA_FETCH_STARV_CNT_EN
  logic [15:0]   starve_count;
`endif

  vga_frame_fetch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vga_frame_fetch_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .frame_start(frame_start),
    .fb_base(fb_base),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done),
    .overrun_sticky(overrun_sticky)
`ifdef VGA_FETCH_STARV_CNT_EN
    ,
    .starve_count(starve_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic u; logic l; } beat_t;
  typedef struct packed { int due; logic [AW-1:0] addr; } rd_t;

  beat_t exp_q[$];
  rd_t   rq[$];
  int    n_pass = 0, n_fail = 0, n_total = 0;
  int    cyc = 0, lat = 2, g_cnt = 0, beat_cnt = 0, done_cnt = 0;
  bit    hold_rv = 1'b0;

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order returns, lat cycles after the grant edge.
  always @(posedge clk) begin
    rd_t r;
    cyc++;
    if (bus.mem_req && bus.mem_gnt) begin
      rq.push_back('{due: cyc + lat - 1, addr: bus.mem_addr});
      g_cnt++;
    end
    #1;
    if (!hold_rv && rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = pix(r.addr);
    end else begin
      bus.mem_rvalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_beat_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 32'(e));
      end
    end
    if (!rst && frame_done) done_cnt++;
  end

  task automatic pulse_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    frame_start = 1'b1;
    fb_base     = base;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    @(posedge clk); #1;
    frame_start = 1'b1;
    fb_base     = base;
    beat_cnt    = 0;
    done_cnt    = 0;
    g_cnt       = 0;
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back('{d: pix(base + AW'(i)), u: (i == 0), l: ((i % H) == H - 1)});
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", 32'(bus.mem_addr), 32'(base));
`ifdef VGA_FETCH_STARV_CNT_EN
    chk("starve_cleared", 32'(starve_count), 32'd0);
`endif
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (beat_cnt >= n) break;
    end
    chk("beats_reached", 32'(beat_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(frame_done), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("beat_count", 32'(beat_cnt), 32'(NPIX));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; fb_base = '0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_tvalid", 32'({bus.m_axis_tvalid, bus.m_axis_tuser, bus.m_axis_tlast}), 32'd0);
    chk("rst_status", 32'({busy, frame_done, overrun_sticky}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame
    start_frame(20'h100);
    wait_done(200);

    // Returns withheld: credit limit caps grants
    hold_rv = 1'b1;
    start_frame(20'h100);
    repeat (20) @(negedge clk);
    chk("credit_grants", 32'(g_cnt), 32'(FD));
    chk("credit_req_low", 32'(bus.mem_req), 32'd0);
    hold_rv = 1'b0;
    wait_done(200);

    // Back-pressure mid-line
    start_frame(20'h100);
    wait_beats(2, 100);
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
      chk("stall_beat", 32'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 32'(exp_q[0]));
    end
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    wait_done(200);

    // frame_start while fetching
    start_frame(20'h100);
    pulse_start(20'h500);
    @(negedge clk);
    chk("overrun_set", 32'(overrun_sticky), 32'd1);
    wait_done(200);
    repeat (10) @(negedge clk);
    chk("no_restart", 32'(busy), 32'd0);
    chk("overrun_sticky_held", 32'(overrun_sticky), 32'd1);

    // enable dropped mid-frame
    start_frame(20'h100);
    wait_beats(2, 100);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_done(200);
    pulse_start(20'h100);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1'b1;
    end
    chk("idle_ignores_start", 32'(seen), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (2) @(posedge clk);

    // Reset mid-frame with long latency so returns are still in flight
    lat = 6;
    start_frame(20'h100);
    wait_beats(5, 200);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_stream", 32'({bus.m_axis_tvalid, bus.m_axis_tuser, bus.m_axis_tlast}), 32'd0);
    chk("mrst_mem", 32'({bus.mem_req, bus.mem_addr}), 32'd0);
    chk("mrst_status", 32'({busy, frame_done, overrun_sticky}), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid) seen = 1'b1;
    end
    chk("stray_ignored", 32'(seen), 32'd0);
    start_frame(20'h200);
    wait_done(300);
`ifdef VGA_FETCH_STARV_CNT_EN
    chk("starve_nonzero", 32'(starve_count != 16'd0), 32'd1);
    start_frame(20'h300);
    wait_done(300);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
